// File: rtl/weight_slice_loader_pkg.sv
// Shared sizing constants for the weight RAM write path and the loader FSM state type.
package weight_slice_loader_pkg;

    localparam int DATA_WIDTH              = 16;
    localparam int KERNEL_SIZE_MAX         = 3;
    localparam int WEIGHT_WRITE_ADDR_WIDTH = 8;
    localparam int CNT_WIDTH               = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_LAST,
        ST_DONE
    } state_e;

endpackage

// File: rtl/weight_slice_loader.sv
// Packs a stream of float16 weights into KERNEL_SIZE_MAX^2-wide slices and writes
// each completed slice to consecutive weight RAM addresses.
module weight_slice_loader
    import weight_slice_loader_pkg::*;
#(
    parameter int DW = DATA_WIDTH,
    parameter int KS = KERNEL_SIZE_MAX,
    parameter int AW = WEIGHT_WRITE_ADDR_WIDTH,
    parameter int CW = CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [3:0]           kernel_size,
    input  logic [CW-1:0]        num_slices,
    input  logic [AW-1:0]        base_addr,
    input  logic                 in_valid,
    input  logic [DW-1:0]        in_data,
    output logic                 in_ready,
    output logic                 ena_w,
    output logic [AW-1:0]        addr_write,
    output logic [KS*KS*DW-1:0]  din,
    output logic                 busy,
    output logic                 done,
    output logic                 cfg_err
);

    localparam int EW = 8;
    localparam int SW = KS * KS * DW;

    state_e        state_q, state_d;
    logic [3:0]    ks_q, ks_d;
    logic [CW-1:0] num_q, num_d;
    logic [AW-1:0] base_q, base_d;
    logic [EW-1:0] elem_q, elem_d;
    logic [CW-1:0] slice_q, slice_d;
    logic [SW-1:0] pack_q, pack_d;
    logic [SW-1:0] din_q, din_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          ena_q, ena_d;
    logic          done_q, done_d;
    logic          cfg_err_q, cfg_err_d;
    logic [EW-1:0] last_elem;

    assign last_elem = EW'(ks_q) * EW'(ks_q) - EW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            ks_q      <= '0;
            num_q     <= '0;
            base_q    <= '0;
            elem_q    <= '0;
            slice_q   <= '0;
            pack_q    <= '0;
            din_q     <= '0;
            addr_q    <= '0;
            ena_q     <= 1'b0;
            done_q    <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ks_q      <= ks_d;
            num_q     <= num_d;
            base_q    <= base_d;
            elem_q    <= elem_d;
            slice_q   <= slice_d;
            pack_q    <= pack_d;
            din_q     <= din_d;
            addr_q    <= addr_d;
            ena_q     <= ena_d;
            done_q    <= done_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ks_d      = ks_q;
        num_d     = num_q;
        base_d    = base_q;
        elem_d    = elem_q;
        slice_d   = slice_q;
        pack_d    = pack_q;
        din_d     = din_q;
        addr_d    = addr_q;
        ena_d     = 1'b0;
        done_d    = 1'b0;
        cfg_err_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (kernel_size == '0 || kernel_size > 4'(KS)) begin
                        cfg_err_d = 1'b1;
                    end else if (num_slices == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = ST_FILL;
                        ks_d    = kernel_size;
                        num_d   = num_slices;
                        base_d  = base_addr;
                        elem_d  = '0;
                        slice_d = '0;
                        pack_d  = '0;
                    end
                end
            end
            ST_FILL: begin
                if (in_valid) begin
                    pack_d[int'(elem_q) * DW +: DW] = in_data;
                    if (elem_q == last_elem) begin
                        // din takes the slice including the beat accepted this edge
                        din_d   = pack_d;
                        addr_d  = base_q + AW'(slice_q);
                        ena_d   = 1'b1;
                        pack_d  = '0;
                        elem_d  = '0;
                        slice_d = slice_q + CW'(1);
                        if (slice_q == num_q - CW'(1)) begin
                            state_d = ST_LAST;
                        end
                    end else begin
                        elem_d = elem_q + EW'(1);
                    end
                end
            end
            ST_LAST: begin
                state_d = ST_DONE;
                done_d  = 1'b1;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign in_ready   = (state_q == ST_FILL);
    assign busy       = (state_q != ST_IDLE);
    assign ena_w      = ena_q;
    assign addr_write = addr_q;
    assign din        = din_q;
    assign done       = done_q;
    assign cfg_err    = cfg_err_q;

endmodule

// File: tb/tb_weight_slice_loader.sv
// Directed bench for weight_slice_loader: expected slices are queued as beats are driven
// and compared against each RAM write pulse.
module tb_weight_slice_loader;

    typedef logic [15:0] w9_t [9];

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [3:0]   kernel_size;
    logic [7:0]   num_slices;
    logic [7:0]   base_addr;
    logic         in_valid;
    logic [15:0]  in_data;
    logic         in_ready;
    logic         ena_w;
    logic [7:0]   addr_write;
    logic [143:0] din;
    logic         busy;
    logic         done;
    logic         cfg_err;

    int checks   = 0;
    int failures = 0;
    int ena_cnt  = 0;
    int pushes   = 0;
    logic [151:0] sb [$];

    weight_slice_loader dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .kernel_size(kernel_size),
        .num_slices (num_slices),
        .base_addr  (base_addr),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .ena_w      (ena_w),
        .addr_write (addr_write),
        .din        (din),
        .busy       (busy),
        .done       (done),
        .cfg_err    (cfg_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [151:0] obs, input logic [151:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every write pulse must match the oldest queued slice.
    always @(negedge clk) begin
        if (ena_w === 1'b1) begin
            logic [151:0] e;
            ena_cnt++;
            chk("sb_pending", 152'(sb.size() > 0), 152'(1));
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("addr_write", 152'(addr_write), 152'(e[151:144]));
                chk("din", 152'(din), 152'(e[143:0]));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_start(input logic [3:0] ks, input logic [7:0] n, input logic [7:0] b);
        kernel_size = ks;
        num_slices  = n;
        base_addr   = b;
        start       = 1'b1;
        @(posedge clk); #1;
        start       = 1'b0;
    endtask

    // Drives one slice; returns #1 after the edge that accepts the final beat.
    task automatic feed_slice(input int ks, input int addr, input w9_t v, input bit toggle);
        logic [143:0] e;
        logic [7:0]   a;
        e = '0;
        a = addr[7:0];
        for (int i = 0; i < ks * ks; i++) e[i*16 +: 16] = v[i];
        sb.push_back({a, e});
        pushes++;
        for (int i = 0; i < ks * ks; i++) begin
            if (toggle && i > 0) begin
                in_valid = 1'b0;
                in_data  = 16'hdead;
                @(posedge clk); #1;
            end
            chk("in_ready_fill", 152'(in_ready), 152'(1));
            in_valid = 1'b1;
            in_data  = v[i];
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_data  = 16'hbeef;
        chk("ena_after_last", 152'(ena_w), 152'(1));
    endtask

    task automatic finish_load();
        chk("last_in_ready", 152'(in_ready), 152'(0));
        chk("last_busy", 152'(busy), 152'(1));
        chk("last_done", 152'(done), 152'(0));
        @(posedge clk); #1;
        chk("done_pulse", 152'(done), 152'(1));
        chk("done_ena", 152'(ena_w), 152'(0));
        chk("done_busy", 152'(busy), 152'(1));
        @(posedge clk); #1;
        chk("post_done", 152'(done), 152'(0));
        chk("post_busy", 152'(busy), 152'(0));
    endtask

    initial begin
        w9_t v1, v2, v3;
        int  wr_before;
        v1 = '{16'h3c00, 16'h4000, 16'h0000, 16'h3c00, 16'h4000, 16'h3c00, 16'h4200, 16'h4000, 16'h3c00};
        v2 = '{16'h1111, 16'h2222, 16'h3333, 16'h3c00, 16'h5555, 16'h6666, 16'h7777, 16'h8888, 16'h9999};
        v3 = '{16'h3c00, 16'h4000, 16'h4200, 16'h4400, 16'hffff, 16'hffff, 16'hffff, 16'hffff, 16'hffff};

        rst = 1'b1; start = 1'b0; kernel_size = '0; num_slices = '0; base_addr = '0;
        in_valid = 1'b0; in_data = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ena", 152'(ena_w), 152'(0));
        chk("rst_busy", 152'(busy), 152'(0));
        chk("rst_ready", 152'(in_ready), 152'(0));
        chk("rst_din", 152'(din), 152'(0));
        chk("rst_addr", 152'(addr_write), 152'(0));
        chk("rst_done_err", 152'({done, cfg_err}), 152'(0));
        rst = 1'b0;
        @(posedge clk); #1;

        // 1: single 3x3 slice, back-to-back beats
        do_start(4'd3, 8'd1, 8'h00);
        chk("s1_busy", 152'(busy), 152'(1));
        feed_slice(3, 0, v1, 1'b0);
        finish_load();

        // 2: two slices with no bubble; a second start mid-load must be ignored
        do_start(4'd3, 8'd2, 8'h00);
        kernel_size = 4'd2; num_slices = 8'd5; base_addr = 8'h70; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        feed_slice(3, 0, v1, 1'b0);
        feed_slice(3, 1, v2, 1'b0);
        finish_load();

        // 3: 2x2 kernel, upper lanes zero
        do_start(4'd2, 8'd1, 8'h05);
        feed_slice(2, 5, v3, 1'b0);
        finish_load();

        // 4: in_valid toggling every cycle
        do_start(4'd3, 8'd1, 8'h00);
        feed_slice(3, 0, v1, 1'b1);
        finish_load();

        // 5: address wrap, bad kernel size, empty load
        do_start(4'd2, 8'd2, 8'hff);
        feed_slice(2, 8'hff, v3, 1'b0);
        feed_slice(2, 0, v2, 1'b0);
        finish_load();

        wr_before = ena_cnt;
        do_start(4'd0, 8'd3, 8'h10);
        chk("ks0_cfg_err", 152'(cfg_err), 152'(1));
        chk("ks0_busy", 152'(busy), 152'(0));
        @(posedge clk); #1;
        chk("ks0_err_clear", 152'(cfg_err), 152'(0));
        do_start(4'd4, 8'd3, 8'h10);
        chk("ks4_cfg_err", 152'(cfg_err), 152'(1));
        chk("ks4_ready", 152'(in_ready), 152'(0));
        @(posedge clk); #1;
        do_start(4'd3, 8'd0, 8'h10);
        chk("n0_done", 152'(done), 152'(1));
        chk("n0_busy", 152'(busy), 152'(0));
        @(posedge clk); #1;
        chk("n0_done_clear", 152'(done), 152'(0));
        chk("no_write_rejects", 152'(ena_cnt), 152'(wr_before));

        // 6: reset after 5 beats, then a clean reload
        do_start(4'd3, 8'd1, 8'h20);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = v2[i];
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_mid_busy", 152'(busy), 152'(0));
        chk("rst_mid_ena", 152'(ena_w), 152'(0));
        chk("rst_mid_done", 152'(done), 152'(0));
        @(posedge clk); #1;
        do_start(4'd3, 8'd1, 8'h20);
        feed_slice(3, 8'h20, v1, 1'b0);
        finish_load();

        repeat (2) @(posedge clk);
        #1;
        chk("sb_drained", 152'(sb.size()), 152'(0));
        chk("write_count", 152'(ena_cnt), 152'(pushes));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
